// File: rtl/fault_injector_pkg.sv
// fault_injector_pkg: shared state encodings, defaults and control-register map for the fault injector
package fault_injector_pkg;

    typedef enum logic [2:0] {
        FI_IDLE  = 3'd0,
        FI_ARMED = 3'd1,
        FI_STALL = 3'd2,
        FI_READ  = 3'd3,
        FI_WRITE = 3'd4,
        FI_DONE  = 3'd5
    } fi_state_e;

    localparam int FI_INJ_CNT_WIDTH = 8;

    // Offsets inside soc_control's CTRL sub-range used to program the injector
    localparam logic [3:0] FI_CTRL_ADDR_REG    = 4'h0;
    localparam logic [3:0] FI_CTRL_ADDR_MASK   = 4'h1;
    localparam logic [3:0] FI_CTRL_ADDR_DELAY  = 4'h2;
    localparam logic [3:0] FI_CTRL_ADDR_CMD    = 4'h3;
    localparam logic [3:0] FI_CTRL_ADDR_STATUS = 4'h4;
    localparam logic [3:0] FI_CTRL_ADDR_ORIG   = 4'h5;
    localparam logic [3:0] FI_CTRL_ADDR_COUNT  = 4'h6;

endpackage

// File: rtl/fault_injector_delay_counter.sv
// fault_injector_delay_counter: loadable down-counter that stops at zero
module fault_injector_delay_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    assign zero_o = cnt_q == '0;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (dec_i && !zero_o)
            cnt_q <= cnt_q - W'(1);
    end

endmodule

// File: rtl/fault_injector.sv
// fault_injector: register-file pass-through that performs a delayed, atomic read-XOR-write
// of one register while holding the CPU stalled.
module fault_injector
    import fault_injector_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32,
    parameter int INJ_CNT_WIDTH  = FI_INJ_CNT_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RSTn,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [REG_ADDR_WIDTH-1:0] cfg_reg,
    input  logic [DATA_WIDTH-1:0]     cfg_mask,
    input  logic [CNT_WIDTH-1:0]      cfg_delay,
    input  logic                      cfg_cancel,
    input  logic                      cpu_stalled,
    output logic                      fi_stall_req,
    input  logic [REG_ADDR_WIDTH-1:0] ctrl_addr,
    input  logic                      ctrl_we,
    input  logic [DATA_WIDTH-1:0]     ctrl_wdata,
    output logic [DATA_WIDTH-1:0]     ctrl_rdata,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr,
    output logic                      rf_we,
    output logic [DATA_WIDTH-1:0]     rf_wdata,
    input  logic [DATA_WIDTH-1:0]     rf_rdata,
    output logic                      fi_armed,
    output logic                      fi_done,
    output logic                      fi_cfg_err,
    output logic                      fi_conflict,
    output logic [DATA_WIDTH-1:0]     fi_orig,
    output logic [INJ_CNT_WIDTH-1:0]  fi_inj_count
);

    fi_state_e                 state_q;
    logic [REG_ADDR_WIDTH-1:0] target_q;
    logic [DATA_WIDTH-1:0]     mask_q, orig_q;
    logic [INJ_CNT_WIDTH-1:0]  inj_cnt_q;
    logic                      cfg_err_q, conflict_q;
    logic                      ready_q, armed_q, stall_q, done_q;
    logic                      own, accept, cnt_dec, cnt_zero;

    assign own     = state_q inside {FI_STALL, FI_READ, FI_WRITE};
    assign accept  = state_q == FI_IDLE && cfg_valid && |cfg_reg;
    assign cnt_dec = state_q == FI_ARMED && !cfg_cancel && !cpu_stalled;

    fault_injector_delay_counter #(.W(CNT_WIDTH)) u_delay (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .load_i     (accept),
        .load_val_i (cfg_delay),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // rf_we during ownership comes from state alone, so a reset can never leave a partial write
    assign rf_addr    = own ? target_q : ctrl_addr;
    assign rf_we      = own ? state_q == FI_WRITE : ctrl_we;
    assign rf_wdata   = own ? orig_q ^ mask_q : ctrl_wdata;
    assign ctrl_rdata = own ? '0 : rf_rdata;

    assign cfg_ready    = ready_q;
    assign fi_armed     = armed_q;
    assign fi_stall_req = stall_q;
    assign fi_done      = done_q;
    assign fi_cfg_err   = cfg_err_q;
    assign fi_conflict  = conflict_q;
    assign fi_orig      = orig_q;
    assign fi_inj_count = inj_cnt_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= FI_IDLE;
            target_q   <= '0;
            mask_q     <= '0;
            orig_q     <= '0;
            inj_cnt_q  <= '0;
            cfg_err_q  <= 1'b0;
            conflict_q <= 1'b0;
            ready_q    <= 1'b1;
            armed_q    <= 1'b0;
            stall_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            armed_q <= 1'b0;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
            if (own && ctrl_we)
                conflict_q <= 1'b1;
            case (state_q)
                FI_IDLE: begin
                    if (accept) begin
                        target_q   <= cfg_reg;
                        mask_q     <= cfg_mask;
                        cfg_err_q  <= 1'b0;
                        conflict_q <= 1'b0;
                        armed_q    <= 1'b1;
                        state_q    <= FI_ARMED;
                    end else begin
                        ready_q <= 1'b1;
                        if (cfg_valid)
                            cfg_err_q <= 1'b1;
                    end
                end
                FI_ARMED: begin
                    if (cfg_cancel) begin
                        ready_q <= 1'b1;
                        state_q <= FI_IDLE;
                    end else if (cnt_zero) begin
                        stall_q <= 1'b1;
                        state_q <= FI_STALL;
                    end else begin
                        armed_q <= 1'b1;
                    end
                end
                FI_STALL: begin
                    stall_q <= 1'b1;
                    state_q <= FI_READ;
                end
                FI_READ: begin
                    orig_q  <= rf_rdata;
                    stall_q <= 1'b1;
                    state_q <= FI_WRITE;
                end
                FI_WRITE: begin
                    if (~&inj_cnt_q)
                        inj_cnt_q <= inj_cnt_q + INJ_CNT_WIDTH'(1);
                    done_q  <= 1'b1;
                    state_q <= FI_DONE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= FI_IDLE;
                end
            endcase
        end
    end

endmodule
